// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state encoding and counter width helpers for the systolic setup path
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SKEW,
    DRAIN,
    DONE
  } setup_state_t;

  // Never return zero so single-value counters still get a real bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int t_width(input int max_k, input int dim);
    return clog2_min1(max_k + dim);
  endfunction

  function automatic int b_width(input int max_k);
    return clog2_min1(max_k + 1);
  endfunction

  function automatic int drain_width(input int drain_cyc);
    return clog2_min1(drain_cyc);
  endfunction

endpackage

// File: rtl/systolic_skew_gen.sv
// rtl/systolic_skew_gen.sv - pyramidal lane read-enable window with empty-lane stall detection
module systolic_skew_gen #(
  parameter int DIM = 8,
  parameter int KW  = 4,
  parameter int TW  = 4
) (
  input  logic            active,
  input  logic [TW-1:0]   t,
  input  logic [KW-1:0]   k,
  input  logic [DIM-1:0]  lane_empty,
  output logic            stall,
  output logic [DIM-1:0]  lane_rd_en,
  output logic [DIM-1:0]  lane_zero
);

  localparam int SW = TW + 1;

  logic [DIM-1:0] window;

  // Lane i reads during steps i .. i+k-1; any empty lane in the window freezes every lane.
  always_comb begin
    window = '0;
    for (int i = 0; i < DIM; i++) begin
      window[i] = active && (SW'(t) >= SW'(i)) && (SW'(t) < SW'(i) + SW'(k));
    end
    stall      = |(window & lane_empty);
    lane_rd_en = stall ? '0 : window;
    lane_zero  = ~lane_rd_en;
  end

endmodule

// File: rtl/systolic_setup_ctrl.sv
// rtl/systolic_setup_ctrl.sv - feed-command sequencer: column load, staggered lane reads, drain, done
// Optional perf counters enabled by SYSTOLIC_SETUP_PERF_EN.
module systolic_setup_ctrl
  import systolic_pkg::*;
#(
  parameter int DIM       = 8,
  parameter int MAX_K     = 8,
  parameter int DRAIN_CYC = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cmd_valid,
  input  logic [$clog2(MAX_K+1)-1:0] cmd_k,
  output logic                       cmd_ready,
  input  logic                       abort,
  output logic                       in_req,
  input  logic                       in_valid,
  input  logic [DIM-1:0]             lane_full,
  input  logic [DIM-1:0]             lane_empty,
  output logic [DIM-1:0]             lane_wr_en,
  output logic [DIM-1:0]             lane_rd_en,
  output logic [DIM-1:0]             lane_zero,
  output logic                       busy,
  output logic                       done,
`ifdef SYSTOLIC_SETUP_PERF_EN
  output logic [31:0]                perf_busy_cyc,
  output logic [31:0]                perf_stall_cyc,
`endif
  output logic                       aborted
);

  localparam int KW  = b_width(MAX_K);
  localparam int TW  = t_width(MAX_K, DIM);
  localparam int DW  = drain_width(DRAIN_CYC);
  localparam int TSW = TW + 1;

  setup_state_t  state_q, state_d;
  logic [KW-1:0] k_q, k_d, k_in;
  logic [KW-1:0] b_q, b_d;
  logic [TW-1:0] t_q, t_d;
  logic [DW-1:0] d_q, d_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          aborted_q, aborted_d;
  logic          stall, t_last;

  assign k_in   = (cmd_k > KW'(MAX_K)) ? KW'(MAX_K) : cmd_k;
  assign t_last = (TSW'(t_q) == TSW'(k_q) + TSW'(DIM - 2));

  systolic_skew_gen #(
    .DIM (DIM),
    .KW  (KW),
    .TW  (TW)
  ) u_skew (
    .active     (state_q == SKEW),
    .t          (t_q),
    .k          (k_q),
    .lane_empty (lane_empty),
    .stall      (stall),
    .lane_rd_en (lane_rd_en),
    .lane_zero  (lane_zero)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    b_d        = b_q;
    t_d        = t_q;
    d_d        = d_q;
    aborted_d  = 1'b0;
    in_req     = 1'b0;
    lane_wr_en = '0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          k_d     = k_in;
          state_d = (k_in == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        in_req = ~|lane_full;
        if (in_req && in_valid) begin
          lane_wr_en = '1;
          b_d        = b_q + KW'(1);
          if (b_q == k_q - KW'(1)) state_d = SKEW;
        end
      end
      SKEW: begin
        if (!stall) begin
          if (t_last) state_d = (DRAIN_CYC == 0) ? DONE : DRAIN;
          else        t_d     = t_q + TW'(1);
        end
      end
      DRAIN: begin
        if (d_q == DW'(DRAIN_CYC - 1)) state_d = DONE;
        else                           d_d     = d_q + DW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides any transition, including the final load beat.
    if (abort && state_q != IDLE) begin
      state_d   = IDLE;
      aborted_d = 1'b1;
    end
    // Every phase starts its own counter from zero.
    if (state_d != state_q) begin
      b_d = '0;
      t_d = '0;
      d_d = '0;
    end
  end

  assign cmd_ready_d = (state_d == IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      b_q         <= '0;
      t_q         <= '0;
      d_q         <= '0;
      cmd_ready_q <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      b_q         <= b_d;
      t_q         <= t_d;
      d_q         <= d_d;
      cmd_ready_q <= cmd_ready_d;
      aborted_q   <= aborted_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign aborted   = aborted_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

`ifdef SYSTOLIC_SETUP_PERF_EN
  logic [31:0] perf_busy_q, perf_busy_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        stall_cyc;

  assign stall_cyc = ((state_q == SKEW) && stall) || ((state_q == LOAD) && !in_req);

  always_comb begin
    perf_busy_d  = perf_busy_q;
    perf_stall_d = perf_stall_q;
    if (busy && (perf_busy_q != '1))       perf_busy_d  = perf_busy_q + 32'd1;
    if (stall_cyc && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_busy_q  <= perf_busy_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_busy_cyc  = perf_busy_q;
  assign perf_stall_cyc = perf_stall_q;
`endif

endmodule
